// File: rtl/fetch_line_fill_if.sv
// Line-fill bus: fetch-stage request/return plus the burst read channel to memory.
// Latency: n/a (wires only).
// Backpressure: valid/ready on the address and beat channels; the line return has none.
//
// Modports:
//   master - the line-fill unit: takes S_R_ADDR*, drives S_R_DATA*; drives M_AR*, M_RREADY.
//   slave  - its environment: the fetch stage plus the memory read port.
interface fetch_line_fill_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
);
    logic [ADDR_WIDTH-1:0]  S_R_ADDR;
    logic                   S_R_ADDR_VALID;
    logic [BUFFER_SIZE-1:0] S_R_DATA;
    logic                   S_R_DATA_VALID;

    logic [ADDR_WIDTH-1:0]  M_ARADDR;
    logic [7:0]             M_ARLEN;
    logic                   M_ARVALID;
    logic                   M_ARREADY;
    logic [DATA_WIDTH-1:0]  M_RDATA;
    logic                   M_RVALID;
    logic                   M_RLAST;
    logic                   M_RREADY;

    modport master (
        input  S_R_ADDR, S_R_ADDR_VALID, M_ARREADY, M_RDATA, M_RVALID, M_RLAST,
        output S_R_DATA, S_R_DATA_VALID, M_ARADDR, M_ARLEN, M_ARVALID, M_RREADY
    );

    modport slave (
        output S_R_ADDR, S_R_ADDR_VALID, M_ARREADY, M_RDATA, M_RVALID, M_RLAST,
        input  S_R_DATA, S_R_DATA_VALID, M_ARADDR, M_ARLEN, M_ARVALID, M_RREADY
    );
endinterface

// File: rtl/fetch_line_fill.sv
// Fills one BUFFER_SIZE-bit line from a single burst read starting at the exact requested byte address.
// Latency: 10 cycles from request to S_R_DATA_VALID with ARREADY=1 and back-to-back beats.
// Backpressure: holds ARVALID/ARADDR until ARREADY; accepts beats whenever RVALID; requests outside IDLE are dropped.
//
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - fetch_line_fill_if.master (fetch request/line return, burst read channel)
module fetch_line_fill #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int BUFFER_SIZE = 512
) (
    input  logic               clk,
    input  logic               reset,
    fetch_line_fill_if.master  bus
);
    localparam int BEATS = BUFFER_SIZE / DATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [7:0]       ARLEN_C = 8'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                 state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [BUFFER_SIZE-1:0] line_q, line_nxt;
    logic [BUFFER_SIZE-1:0] sdata_q, sdata_nxt;
    logic                   sdata_vld_q, sdata_vld_nxt;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_nxt;
    logic                   arvalid_q, arvalid_nxt;
    logic                   rready_q, rready_nxt;

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        line_nxt      = line_q;
        sdata_nxt     = sdata_q;
        sdata_vld_nxt = 1'b0;
        araddr_nxt    = araddr_q;
        arvalid_nxt   = arvalid_q;
        rready_nxt    = rready_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.S_R_ADDR_VALID) begin
                    araddr_nxt  = bus.S_R_ADDR;
                    line_nxt    = '0;
                    cnt_nxt     = '0;
                    arvalid_nxt = 1'b1;
                    state_nxt   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arvalid_q && bus.M_ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.M_RVALID && rready_q) begin
                    // Beats beyond a full line are accepted so the burst can drain, but dropped.
                    if (cnt_q < BEATS_C) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt_q == CNT_W'(b)) begin
                                line_nxt[b*DATA_WIDTH +: DATA_WIDTH] = bus.M_RDATA;
                            end
                        end
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                    // A short burst leaves the unfilled upper beats at zero.
                    if (bus.M_RLAST) begin
                        rready_nxt    = 1'b0;
                        sdata_nxt     = line_nxt;
                        sdata_vld_nxt = 1'b1;
                        state_nxt     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            sdata_q     <= '0;
            sdata_vld_q <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            line_q      <= line_nxt;
            sdata_q     <= sdata_nxt;
            sdata_vld_q <= sdata_vld_nxt;
            araddr_q    <= araddr_nxt;
            arvalid_q   <= arvalid_nxt;
            rready_q    <= rready_nxt;
        end
    end

    assign bus.S_R_DATA       = sdata_q;
    assign bus.S_R_DATA_VALID = sdata_vld_q;
    assign bus.M_ARADDR       = araddr_q;
    assign bus.M_ARLEN        = ARLEN_C;
    assign bus.M_ARVALID      = arvalid_q;
    assign bus.M_RREADY       = rready_q;
endmodule

// File: tb/tb_fetch_line_fill.sv
// Bench for fetch_line_fill: table rows, randomized bursts, and a mid-burst reset sequence.
// Latency: n/a.
// Backpressure: the bench plays memory, stalling ARREADY and gapping RVALID per row.
module tb_fetch_line_fill;
    logic clk;
    logic reset;

    fetch_line_fill_if bus ();

    fetch_line_fill dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observations taken on the falling edge, away from the register updates.
    int               cyc      = 0;
    int               vld_cnt  = 0;
    int               vld_cyc  = 0;
    int               ar_cnt   = 0;
    logic [511:0]     vld_line = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.S_R_DATA_VALID === 1'b1) begin
            vld_cnt  <= vld_cnt + 1;
            vld_cyc  <= cyc + 1;
            vld_line <= bus.S_R_DATA;
        end
        if (bus.M_ARVALID === 1'b1 && bus.M_ARREADY === 1'b1) begin
            ar_cnt <= ar_cnt + 1;
        end
    end

    logic [63:0]  beats [16];
    logic [511:0] prev_exp = '0;

    typedef struct {
        logic [63:0] addr;
        int          aw;       // cycles ARREADY is held low
        int          gap;      // idle cycles before every beat
        int          nb;       // beats sent, RLAST on the last
        int          pat;      // 0: index bytes, 1: random, 2: 0xAA fill
        int          inj;      // beat index carrying a stray request; nb = during DONE; -1 none
        int          exp_lat;  // request cycle to valid cycle
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected line: first min(nb, 8) beats packed little-endian, the rest zero.
    function automatic logic [511:0] model_line(input int nb);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < nb && i < 8; i++) l[i*64 +: 64] = beats[i];
        return l;
    endfunction

    task automatic txn(input logic [63:0] addr, input int aw, input int gap, input int nb,
                       input int inj, input int exp_lat);
        int           v0, a0, req_cyc;
        logic         hold_ok, rr_ok;
        logic [511:0] exp;
        exp = model_line(nb);
        v0  = vld_cnt;
        a0  = ar_cnt;

        @(posedge clk); #1;
        bus.S_R_ADDR       = addr;
        bus.S_R_ADDR_VALID = 1'b1;
        req_cyc            = cyc + 1;
        @(posedge clk); #1;
        bus.S_R_ADDR_VALID = 1'b0;
        chk("araddr", 512'(bus.M_ARADDR), 512'(addr));
        chk("arvalid", 512'(bus.M_ARVALID), 512'(1));
        chk("arlen", 512'(bus.M_ARLEN), 512'(7));
        chk("data_hold_prev", bus.S_R_DATA, prev_exp);

        hold_ok = 1'b1;
        for (int w = 0; w < aw; w++) begin
            @(posedge clk); #1;
            if (!(bus.M_ARVALID === 1'b1 && bus.M_ARADDR === addr)) hold_ok = 1'b0;
        end
        if (aw > 0) chk("ar_stable", 512'(hold_ok), 512'(1));

        bus.M_ARREADY = 1'b1;
        @(posedge clk); #1;
        bus.M_ARREADY = 1'b0;

        rr_ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.M_RVALID = 1'b0;
                @(posedge clk); #1;
            end
            bus.M_RVALID = 1'b1;
            bus.M_RDATA  = beats[i];
            bus.M_RLAST  = (i == nb - 1);
            if (i == inj) begin
                bus.S_R_ADDR       = addr ^ 64'hF0F0;
                bus.S_R_ADDR_VALID = 1'b1;
            end
            if (bus.M_RREADY !== 1'b1) rr_ok = 1'b0;
            @(posedge clk); #1;
            bus.S_R_ADDR_VALID = 1'b0;
        end
        bus.M_RVALID = 1'b0;
        bus.M_RLAST  = 1'b0;
        if (inj == nb) begin
            bus.S_R_ADDR       = addr ^ 64'hF0F0;
            bus.S_R_ADDR_VALID = 1'b1;
            @(posedge clk); #1;
            bus.S_R_ADDR_VALID = 1'b0;
        end
        chk("rready_in_data", 512'(rr_ok), 512'(1));

        repeat (3) @(posedge clk);
        #1;
        chk("valid_pulses", 512'(vld_cnt - v0), 512'(1));
        chk("ar_handshakes", 512'(ar_cnt - a0), 512'(1));
        chk("latency", 512'(vld_cyc - req_cyc), 512'(exp_lat));
        chk("line", vld_line, exp);
        chk("first32", 512'(vld_line[31:0]), 512'(beats[0][31:0]));
        chk("data_held", bus.S_R_DATA, exp);
        chk("idle_outputs", 512'({bus.M_ARVALID, bus.M_RREADY, bus.S_R_DATA_VALID}), 512'(0));
        prev_exp = exp;
    endtask

    initial begin
        int aw, gap, nb;
        logic [63:0] addr;

        reset              = 1'b1;
        bus.S_R_ADDR       = '0;
        bus.S_R_ADDR_VALID = 1'b0;
        bus.M_ARREADY      = 1'b0;
        bus.M_RDATA        = '0;
        bus.M_RVALID       = 1'b0;
        bus.M_RLAST        = 1'b0;
        for (int i = 0; i < 16; i++) beats[i] = '0;

        tbl[0] = '{64'h1000, 0, 0,  8, 0, -1, 10};
        tbl[1] = '{64'h2000, 5, 1,  8, 1, -1, 23};
        tbl[2] = '{64'h1004, 0, 0,  8, 1, -1, 10};
        tbl[3] = '{64'h3000, 0, 0,  4, 2, -1,  6};
        tbl[4] = '{64'h4000, 1, 0, 10, 1, -1, 13};
        tbl[5] = '{64'h5000, 0, 0,  8, 1,  3, 10};
        tbl[6] = '{64'h6000, 0, 0,  8, 1,  8, 10};
        tbl[7] = '{64'h7000, 2, 0,  8, 0, -1, 12};

        #22;
        chk("rst_sdata", bus.S_R_DATA, 512'(0));
        chk("rst_valid", 512'(bus.S_R_DATA_VALID), 512'(0));
        chk("rst_arvalid", 512'(bus.M_ARVALID), 512'(0));
        chk("rst_araddr", 512'(bus.M_ARADDR), 512'(0));
        chk("rst_rready", 512'(bus.M_RREADY), 512'(0));
        #1 reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                case (tbl[r].pat)
                    0:       beats[i] = 64'(i) * 64'h0101_0101_0101_0101;
                    2:       beats[i] = 64'hAAAA_AAAA_AAAA_AAAA;
                    default: beats[i] = {$urandom, $urandom};
                endcase
            end
            txn(tbl[r].addr, tbl[r].aw, tbl[r].gap, tbl[r].nb, tbl[r].inj, tbl[r].exp_lat);
        end

        for (int k = 0; k < 20; k++) begin
            addr = {$urandom, $urandom};
            aw   = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            nb   = $urandom_range(1, 11);
            for (int i = 0; i < 16; i++) beats[i] = {$urandom, $urandom};
            txn(addr, aw, gap, nb, -1, 2 + aw + nb * (1 + gap));
        end

        // Reset in the middle of a burst, after four beats.
        @(posedge clk); #1;
        bus.S_R_ADDR       = 64'h8000;
        bus.S_R_ADDR_VALID = 1'b1;
        @(posedge clk); #1;
        bus.S_R_ADDR_VALID = 1'b0;
        bus.M_ARREADY      = 1'b1;
        @(posedge clk); #1;
        bus.M_ARREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.M_RVALID = 1'b1;
            bus.M_RDATA  = 64'hDEAD_0000_0000_0000 + 64'(i);
            @(posedge clk); #1;
        end
        bus.M_RVALID = 1'b0;
        chk("pre_rst_rready", 512'(bus.M_RREADY), 512'(1));
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_sdata", bus.S_R_DATA, 512'(0));
        chk("mid_rst_valid", 512'(bus.S_R_DATA_VALID), 512'(0));
        chk("mid_rst_arvalid", 512'(bus.M_ARVALID), 512'(0));
        chk("mid_rst_araddr", 512'(bus.M_ARADDR), 512'(0));
        chk("mid_rst_rready", 512'(bus.M_RREADY), 512'(0));
        #1 reset = 1'b0;
        prev_exp = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 16; i++) beats[i] = {$urandom, $urandom};
        txn(64'h9000, 0, 0, 2, -1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_line_fill.md
Name: fetch_line_fill

Overview:
- Upstream neighbour of the fetch stage. Serves the fetch stage's single-line read request (S_R_ADDR / S_R_ADDR_VALID).
- Issues one burst read on a 64-bit memory read channel and assembles the returned beats into a BUFFER_SIZE-bit line.
- Returns the line on S_R_DATA with a one-cycle S_R_DATA_VALID pulse.
- Line content starts at the exact requested byte address. The fetch stage indexes the line from that address.

Parameters:
- ADDR_WIDTH, 64, byte-address width.
- DATA_WIDTH, 64, memory read-data beat width in bits.
- BUFFER_SIZE, 512, line width in bits. BEATS = BUFFER_SIZE/DATA_WIDTH = 8 (derived, localparam). BUFFER_SIZE must be a multiple of DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- S_R_ADDR  input  ADDR_WIDTH  requested line start byte address.
- S_R_ADDR_VALID  input  1  request strobe; may be a single-cycle pulse.
- S_R_DATA  output  BUFFER_SIZE  assembled line.
- S_R_DATA_VALID  output  1  one-cycle completion pulse.
- M_ARADDR  output  ADDR_WIDTH  burst start byte address.
- M_ARLEN  output  8  beats minus one (constant BEATS-1 = 7).
- M_ARVALID  output  1  address-channel valid.
- M_ARREADY  input  1  address-channel ready.
- M_RDATA  input  DATA_WIDTH  read beat.
- M_RVALID  input  1  beat valid.
- M_RLAST  input  1  last beat of burst.
- M_RREADY  output  1  beat ready.

Behaviour:
- All outputs are registered.
- Reset (async, any state, including mid-burst): state=IDLE, beat count=0, line register=0.
  - Outputs at reset: S_R_DATA=0, S_R_DATA_VALID=0, M_ARVALID=0, M_ARADDR=0, M_RREADY=0.
  - Any burst in flight is abandoned. The memory side is responsible for draining it.
- States: IDLE, ADDR, DATA, DONE.
- IDLE: on an edge with S_R_ADDR_VALID=1, latch M_ARADDR<=S_R_ADDR, clear the line register and beat count, set M_ARVALID<=1, go to ADDR.
- ADDR: hold M_ARVALID and M_ARADDR stable until the edge with M_ARVALID&M_ARREADY.
  - At that edge: M_ARVALID<=0, M_RREADY<=1, go to DATA.
- DATA: each edge with M_RVALID&M_RREADY stores M_RDATA into line bits [cnt*DATA_WIDTH +: DATA_WIDTH], then cnt++.
  - Byte k of the line is byte M_ARADDR+k, little-endian.
  - Burst completes on the accepted beat with M_RLAST=1. At that edge: M_RREADY<=0, go to DONE.
  - Beats accepted when cnt=BEATS (excess beats before RLAST) are discarded; the line is not modified. The unit stays in DATA until RLAST.
  - RLAST before BEATS beats: unfilled upper beats remain 0 and the burst completes normally.
- DONE: exactly one cycle. S_R_DATA_VALID=1 and S_R_DATA=assembled line; next state IDLE.
- S_R_DATA holds its last value until the next DONE. S_R_DATA_VALID=0 in every other state.
- Requests while not in IDLE (including during DONE) are ignored, not queued.
- M_ARLEN is constant 7 for default parameters.
- Address arithmetic: the burst covers bytes M_ARADDR .. M_ARADDR+BUFFER_SIZE/8-1, with no alignment applied. Wrap past 2^ADDR_WIDTH is the memory side's concern; this block only presents M_ARADDR.
- Minimum latency, with ARREADY=1 and RVALID every cycle:
  - Request sampled at edge T.
  - AR handshake at T+1.
  - Beats at T+2..T+9.
  - S_R_DATA_VALID high in the cycle after edge T+9, i.e. 10 cycles after request.
- Back-to-back: the earliest next request is sampled at the edge ending the DONE cycle's successor (in IDLE).

Test Plan:
- Reset, then request S_R_ADDR=0x1000 pulse (1 cycle) with ARREADY=1 and RDATA=beat index i replicated, RLAST on beat 7 -> M_ARADDR=0x1000, M_ARLEN=7; S_R_DATA[64i+:64]=i; S_R_DATA_VALID high exactly 1 cycle, 10 cycles after the request.
- ARREADY held low 5 cycles, RVALID gapped (every other cycle) -> ARVALID and ARADDR stable throughout the wait; beats assembled in order; single valid pulse after the 8th beat.
- Unaligned request S_R_ADDR=0x1004 -> M_ARADDR=0x1004; first beat lands in bits [63:0]; S_R_DATA[31:0] equals the first 32 bits of that beat.
- RLAST on beat 3 (4 beats of 0xAA..) -> bits [511:256]=0; valid pulse issued. Then 10 beats with RLAST on the 10th -> only the first 8 stored; valid pulse after the 10th beat.
- Second S_R_ADDR_VALID asserted during DATA -> ignored; no second AR issued; next request in IDLE is served normally.
- Async reset asserted mid-DATA (after beat 4) -> all outputs 0 immediately without a clock edge; state IDLE; the next request produces a clean line with no stale beats.
